periferico_bin2bcd: RTL
=======================

// Module: periferico_bin2bcd
// PURPOSE
//  Memory-mapped binary-to-BCD converter peripheral on the same CPU bus as the BCD-to-binary
//  peripheral; sits downstream of the calculator ALU and feeds the display path.
//  CPU writes a binary result, pulses start, polls status, reads packed BCD (5 digits).
//  Conversion is sequential shift-add-3 (double dabble), one bit per clock.
// PARAMETERS
//  ANCHO_BIN  17  operand width used (bits [ANCHO_BIN-1:0] of the written word; rest ignored)
//  DIGITOS    5   BCD digits returned (result packed in [4*DIGITOS-1:0], upper bits 0)
// PORTS
//  reloj              in   1   clock, all state on rising edge
//  reset              in   1   asynchronous, active-high reset
//  dato_entrada       in   32  bus write data
//  habilitacion_chip  in   1   chip select; leer/escribir ignored when 0
//  direccion          in   5   byte address: 0x04 operand(RW), 0x0C control(W), 0x10 result(R), 0x14 status(R)
//  leer               in   1   read strobe (one cycle)
//  escribir           in   1   write strobe (one cycle)
//  dato_salida        out  32  registered read data
// BEHAVIOUR
//  Reset (async): all registers 0, FSM ESPERA, dato_salida=0, status=0; applies mid-conversion too (conversion aborted).
//  Write (cs&escribir at edge): 0x04 -> operando <= dato_entrada[ANCHO_BIN-1:0];
//   0x0C bit0=1 -> start request; other addresses/bits ignored.
//  Read (cs&leer at edge): dato_salida <= selected reg at that edge (1-cycle latency); holds value otherwise.
//   0x04 operand (zero-extended), 0x10 resultado, 0x14 {29'b0, desbordado, ocupado, terminado}, others 0.
//  FSM ESPERA -> CONVIERTE on start at edge k: shift reg <= operando, BCD accumulator (DIGITOS+1 digits)
//   <= 0, cuenta <= ANCHO_BIN, terminado <= 0, desbordado <= 0, ocupado <= 1.
//  CONVIERTE, each edge: every accumulator digit >=5 gets +3, then {acc,shift} shifted left 1; cuenta-1.
//  At edge k+ANCHO_BIN (last shift): resultado <= low DIGITOS digits, desbordado <= (extra top digit != 0),
//   terminado <= 1, ocupado <= 0, FSM -> ESPERA. Latency start->terminado = ANCHO_BIN cycles.
//  Overflow (operand > 10^DIGITOS-1): resultado = operand mod 10^DIGITOS, desbordado=1.
//  Start while CONVIERTE: ignored. Operand write while CONVIERTE: operando updated, running conversion
//   unaffected (uses its load-time copy). Simultaneous status read on completion edge returns pre-edge status.
//  terminado/desbordado/resultado hold until next accepted start or reset.
// TESTING
//  Write 0x04=0x3039 (12345), 0x0C=1 -> ocupado=1 next cycle; terminado rises 17 cycles after start; read 0x10 -> 0x00012345.
//  Operand 0 -> result 0x00000000, desbordado 0; operand 99999 -> 0x00099999, desbordado 0.
//  Operand 100000 -> result 0x00000000, desbordado 1; operand 131071 -> 0x00031071, desbordado 1.
//  Start at k, second start at k+5 with new operand 42 -> ignored, completion still at k+17 with first result.
//  Assert reset at k+8 mid-conversion -> immediately status 0, result 0; next start with 0x3039 converts normally.
//  Write 0xFFFE3039 to 0x04 -> upper bits ignored, readback 0x00003039; reads at unmapped 0x08 -> 0.

Source files
------------

// File: rtl/periferico_bin2bcd.sv
// Bus-mapped binary-to-BCD converter: the CPU loads an operand, pulses start, polls status
// and reads packed BCD. Conversion is sequential double dabble, one operand bit per clock.
module periferico_bin2bcd #(
    parameter int ANCHO_BIN = 17,
    parameter int DIGITOS   = 5
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic [31:0] dato_entrada,
    input  logic        habilitacion_chip,
    input  logic [4:0]  direccion,
    input  logic        leer,
    input  logic        escribir,
    output logic [31:0] dato_salida
);

    localparam int ANCHO_ACC = 4 * (DIGITOS + 1);
    localparam int ANCHO_RES = 4 * DIGITOS;
    localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);
    localparam logic [ANCHO_CNT-1:0] CUENTA_INI = ANCHO_CNT'(ANCHO_BIN);

    localparam logic [4:0] DIR_OPERANDO  = 5'h04;
    localparam logic [4:0] DIR_CONTROL   = 5'h0C;
    localparam logic [4:0] DIR_RESULTADO = 5'h10;
    localparam logic [4:0] DIR_ESTADO    = 5'h14;

    typedef enum logic {ESPERA, CONVIERTE} estado_t;

    estado_t                estado;
    logic [ANCHO_BIN-1:0]   operando;
    logic [ANCHO_BIN-1:0]   desplazamiento;
    logic [ANCHO_ACC-1:0]   acumulador;
    logic [ANCHO_CNT-1:0]   cuenta;
    logic [ANCHO_RES-1:0]   resultado;
    logic                   terminado;
    logic                   ocupado;
    logic                   desbordado;

    logic                   escritura;
    logic                   lectura;
    logic                   arranque;
    logic [ANCHO_ACC-1:0]   acc_ajustado;
    logic [ANCHO_ACC-1:0]   acc_siguiente;
    logic [31:0]            dato_leido;
    logic                   unused_bits;

    assign escritura = habilitacion_chip && escribir;
    assign lectura   = habilitacion_chip && leer;
    assign arranque  = escritura && (direccion == DIR_CONTROL) && dato_entrada[0];

    // The top bit of the adjusted accumulator always shifts out; the extra digit keeps it zero
    // for any operand that fits, so dropping it never loses a result bit that matters.
    assign unused_bits = ^{dato_entrada[31:ANCHO_BIN], acc_ajustado[ANCHO_ACC-1]};

    // NOTE: every combinational output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        acc_ajustado = acumulador;
        for (int i = 0; i < DIGITOS + 1; i++) begin
            if (acumulador[4*i +: 4] >= 4'd5)
                acc_ajustado[4*i +: 4] = acumulador[4*i +: 4] + 4'd3;
        end
        acc_siguiente = {acc_ajustado[ANCHO_ACC-2:0], desplazamiento[ANCHO_BIN-1]};
    end

    always_comb begin
        dato_leido = 32'd0;
        case (direccion)
            DIR_OPERANDO:  dato_leido = {{(32-ANCHO_BIN){1'b0}}, operando};
            DIR_RESULTADO: dato_leido = {{(32-ANCHO_RES){1'b0}}, resultado};
            DIR_ESTADO:    dato_leido = {29'd0, desbordado, ocupado, terminado};
            default:       dato_leido = 32'd0;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado         <= ESPERA;
            operando       <= '0;
            desplazamiento <= '0;
            acumulador     <= '0;
            cuenta         <= '0;
            resultado      <= '0;
            terminado      <= 1'b0;
            ocupado        <= 1'b0;
            desbordado     <= 1'b0;
            dato_salida    <= 32'd0;
        end else begin
            if (escritura && (direccion == DIR_OPERANDO))
                operando <= dato_entrada[ANCHO_BIN-1:0];

            if (lectura)
                dato_salida <= dato_leido;

            case (estado)
                ESPERA: begin
                    if (arranque) begin
                        desplazamiento <= operando;
                        acumulador     <= '0;
                        cuenta         <= CUENTA_INI;
                        terminado      <= 1'b0;
                        desbordado     <= 1'b0;
                        ocupado        <= 1'b1;
                        estado         <= CONVIERTE;
                    end
                end
                CONVIERTE: begin
                    // Start requests are dropped here; the running job owns its load-time copy.
                    acumulador     <= acc_siguiente;
                    desplazamiento <= {desplazamiento[ANCHO_BIN-2:0], 1'b0};
                    cuenta         <= cuenta - ANCHO_CNT'(1);
                    if (cuenta == ANCHO_CNT'(1)) begin
                        resultado  <= acc_siguiente[ANCHO_RES-1:0];
                        desbordado <= |acc_siguiente[ANCHO_ACC-1:ANCHO_RES];
                        terminado  <= 1'b1;
                        ocupado    <= 1'b0;
                        estado     <= ESPERA;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
